vga_sync_ctrl: RTL

- Sequences the 25 MHz pixel rate from the 50 MHz board clock into 640x480@60 Hz VGA timing.
- Outputs: horizontal/vertical sync, visible-area flag, pixel coordinates, line/frame strobes.
- Sits between the clock divider and the DrumsHero renderer (note lanes, score overlay); the renderer consumes pixel_x/pixel_y/video_on.
- Single clock domain: clk stays 50 MHz; pixel advance uses a clock-enable, never a derived clock.

---
 rtl/vga_sync_ctrl_if.sv | 22 ++
 rtl/vga_sync_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/vga_sync_ctrl_if.sv
// Timing bus between the VGA sync generator and the renderer.
// master = sync generator (drives timing, samples pix_en); slave = renderer/strobe source.
interface vga_sync_ctrl_if;
  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_tick;
  logic       frame_tick;

  modport master (
    input  pix_en,
    output hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick
  );
endinterface

// File: rtl/vga_sync_ctrl.sv
// VGA timing generator: h/v counters advanced by a pixel clock-enable on the 50 MHz clock.
// Sync/video/strobe flags are registered from next-state counts, so they align with pixel_x/pixel_y.
module vga_sync_ctrl #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter bit          SYNC_ACTIVE = 1'b0,
  parameter bit          USE_INT_DIV = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_sync_ctrl_if.master bus
);
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_size_chk
    $error("vga_sync_ctrl: timing totals do not fit the 10-bit counters");
  end

  logic       r_div;
  logic       r_started;
  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_line_tick;
  logic       r_frame_tick;

  logic       w_tick;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;

  always_comb begin
    w_tick   = USE_INT_DIV ? r_div : bus.pix_en;
    w_h_wrap = (r_h_cnt == H_LAST);
    w_v_wrap = (r_v_cnt == V_LAST);
    w_h_nxt  = r_h_cnt;
    w_v_nxt  = r_v_cnt;
    if (w_tick) begin
      w_h_nxt = w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
      if (w_h_wrap) begin
        w_v_nxt = w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
      end
    end
  end

  // Flags are computed from w_*_nxt so they change on the same edge as the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div        <= 1'b0;
      r_started    <= 1'b0;
      r_h_cnt      <= 10'd0;
      r_v_cnt      <= 10'd0;
      r_hsync      <= ~SYNC_ACTIVE;
      r_vsync      <= ~SYNC_ACTIVE;
      r_video_on   <= 1'b0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_div        <= ~r_div;
      r_started    <= r_started | w_tick;
      r_h_cnt      <= w_h_nxt;
      r_v_cnt      <= w_v_nxt;
      r_hsync      <= ((w_h_nxt >= H_SYNC_BEG) && (w_h_nxt < H_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_vsync      <= ((w_v_nxt >= V_SYNC_BEG) && (w_v_nxt < V_SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      r_video_on   <= (r_started | w_tick) && (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
      r_line_tick  <= w_tick && w_h_wrap;
      r_frame_tick <= w_tick && w_h_wrap && w_v_wrap;
    end
  end

  assign bus.hsync      = r_hsync;
  assign bus.vsync      = r_vsync;
  assign bus.video_on   = r_video_on;
  assign bus.pixel_x    = r_h_cnt;
  assign bus.pixel_y    = r_v_cnt;
  assign bus.line_tick  = r_line_tick;
  assign bus.frame_tick = r_frame_tick;
endmodule
